memory_controller: RTL and testbench

//  Arbitrates the single byte-wide RAM port between instruction fetch (IF) and the load/store buffer (LSB).

---
 rtl/mem_ctrl_pkg.sv | 24 ++
 rtl/mem_load_extend.sv | 21 ++
 rtl/memory_controller.sv | 201 ++++++++++++++++++++
 tb/tb_memory_controller.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared types and encodings for the byte-serial memory controller.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} mem_state_e;

    localparam logic [1:0]  LEN_1B = 2'b00;
    localparam logic [1:0]  LEN_2B = 2'b01;
    localparam logic [1:0]  LEN_4B = 2'b11;

    localparam logic        GRANT_IF  = 1'b0;
    localparam logic        GRANT_LSB = 1'b1;

    localparam logic [31:0] IO_BASE_DEFAULT = 32'h0003_0000;

    // Index of the last byte of a burst; the illegal encoding 2'b10 runs as a word.
    function automatic logic [2:0] len_last(input logic [1:0] len);
        case (len)
            LEN_1B:  len_last = 3'd0;
            LEN_2B:  len_last = 3'd1;
            default: len_last = 3'd3;
        endcase
    endfunction

endpackage

// File: rtl/mem_load_extend.sv
// Combinational load formatter: keeps the low len bytes of the assembled word
// and sign- or zero-extends 1B/2B results.
module mem_load_extend
    import mem_ctrl_pkg::*;
(
    input  logic [31:0] i_bytes,
    input  logic [1:0]  i_len,
    input  logic        i_signed,
    output logic [31:0] o_data
);

    always_comb begin
        o_data = i_bytes;
        case (i_len)
            LEN_1B:  o_data = {{24{i_signed & i_bytes[7]}}, i_bytes[7:0]};
            LEN_2B:  o_data = {{16{i_signed & i_bytes[15]}}, i_bytes[15:0]};
            default: o_data = i_bytes;
        endcase
    end

endmodule

// File: rtl/memory_controller.sv
// Arbitrates the byte-wide RAM port between IF and LSB and runs each request as a byte burst.
// Optional MEM_CTRL_IO_STALL_EN holds IO-region store bytes while io_buffer_full is high.
module memory_controller
    import mem_ctrl_pkg::*;
#(
    parameter logic [31:0] IO_BASE = IO_BASE_DEFAULT
)
(
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        rdy_in,
    input  logic        clear_signal,
    input  logic        if_signal,
    input  logic [31:0] if_addr,
    output logic        if_done,
    output logic [31:0] if_data,
    input  logic        lsb_signal,
    input  logic        lsb_wr,
    input  logic        lsb_signed,
    input  logic [1:0]  lsb_len,
    input  logic [31:0] lsb_addr,
    input  logic [31:0] lsb_wdata,
    output logic [31:0] lsb_rdata,
    output logic        lsb_done,
    input  logic [7:0]  ram_din,
    output logic [7:0]  ram_dout,
    output logic [31:0] ram_a,
    output logic        ram_wr,
    input  logic        io_buffer_full,
    output mem_state_e  o_dbg_state
);

    mem_state_e  r_state;
    logic [2:0]  r_cnt;
    logic [2:0]  r_last;
    logic        r_grant;
    logic        r_last_grant;
    logic        r_signed;
    logic [1:0]  r_len;
    logic [31:0] r_wdata;
    logic [31:0] r_buf;
    logic [31:0] r_ram_a;
    logic [7:0]  r_ram_dout;
    logic        r_ram_wr;
    logic        r_if_done;
    logic        r_lsb_done;
    logic [31:0] r_if_data;
    logic [31:0] r_lsb_rdata;

    logic        w_io_full;
    logic        w_if_req;
    logic        w_lsb_req;
    logic        w_pick_lsb;
    logic        w_any;
    logic [31:0] w_base;
    logic [31:0] w_ram_a_next;
    logic        w_stall_start;
    logic        w_stall_next;
    logic        w_stall_cur;
    logic [31:0] w_assembled;
    logic [31:0] w_ext;

`ifdef MEM_CTRL_IO_STALL_EN
    assign w_io_full = io_buffer_full;
`else
    logic w_unused_io_full;
    assign w_unused_io_full = io_buffer_full;
    assign w_io_full        = 1'b0;
`endif

    // A flush blocks everything except a store, which must still reach memory.
    assign w_if_req   = if_signal & ~clear_signal;
    assign w_lsb_req  = lsb_signal & (~clear_signal | lsb_wr);
    assign w_pick_lsb = w_lsb_req & (~w_if_req | (r_last_grant == GRANT_IF));
    assign w_any      = w_if_req | w_lsb_req;
    assign w_base     = w_pick_lsb ? lsb_addr : if_addr;

    assign w_ram_a_next  = r_ram_a + 32'd1;
    assign w_stall_start = w_io_full & (w_base[31:16] == IO_BASE[31:16]);
    assign w_stall_next  = w_io_full & (w_ram_a_next[31:16] == IO_BASE[31:16]);
    assign w_stall_cur   = w_io_full & (r_ram_a[31:16] == IO_BASE[31:16]);

    // ram_din in READ count c is the byte addressed at count c-1.
    always_comb begin
        w_assembled = r_buf;
        case (r_cnt)
            3'd1:    w_assembled[7:0]   = ram_din;
            3'd2:    w_assembled[15:8]  = ram_din;
            3'd3:    w_assembled[23:16] = ram_din;
            3'd4:    w_assembled[31:24] = ram_din;
            default: w_assembled = r_buf;
        endcase
    end

    mem_load_extend u_extend (
        .i_bytes  (w_assembled),
        .i_len    (r_len),
        .i_signed (r_signed),
        .o_data   (w_ext)
    );

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state      <= IDLE;
            r_cnt        <= 3'd0;
            r_last       <= 3'd0;
            r_grant      <= GRANT_IF;
            r_last_grant <= GRANT_IF;
            r_signed     <= 1'b0;
            r_len        <= LEN_4B;
            r_wdata      <= 32'd0;
            r_buf        <= 32'd0;
            r_ram_a      <= 32'd0;
            r_ram_dout   <= 8'd0;
            r_ram_wr     <= 1'b0;
            r_if_done    <= 1'b0;
            r_lsb_done   <= 1'b0;
            r_if_data    <= 32'd0;
            r_lsb_rdata  <= 32'd0;
        end else if (rdy_in) begin
            r_if_done  <= 1'b0;
            r_lsb_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_grant      <= w_pick_lsb ? GRANT_LSB : GRANT_IF;
                        r_last_grant <= w_pick_lsb ? GRANT_LSB : GRANT_IF;
                        r_len        <= w_pick_lsb ? lsb_len : LEN_4B;
                        r_last       <= len_last(w_pick_lsb ? lsb_len : LEN_4B);
                        r_signed     <= w_pick_lsb & lsb_signed;
                        r_cnt        <= 3'd0;
                        r_buf        <= 32'd0;
                        r_ram_a      <= w_base;
                        if (w_pick_lsb && lsb_wr) begin
                            r_state    <= WRITE;
                            r_wdata    <= lsb_wdata;
                            r_ram_dout <= lsb_wdata[7:0];
                            r_ram_wr   <= ~w_stall_start;
                        end else begin
                            r_state  <= READ;
                            r_ram_wr <= 1'b0;
                        end
                    end
                end
                READ: begin
                    if (clear_signal) begin
                        r_state <= IDLE;
                    end else begin
                        r_buf <= w_assembled;
                        if (r_cnt == r_last + 3'd1) begin
                            r_state <= DONE;
                            if (r_grant == GRANT_IF) begin
                                r_if_data <= w_ext;
                                r_if_done <= 1'b1;
                            end else begin
                                r_lsb_rdata <= w_ext;
                                r_lsb_done  <= 1'b1;
                            end
                        end else begin
                            r_cnt <= r_cnt + 3'd1;
                            if (r_cnt < r_last) r_ram_a <= w_ram_a_next;
                        end
                    end
                end
                WRITE: begin
                    // ram_wr low here means the current byte was held back and is retried.
                    if (r_ram_wr) begin
                        if (r_cnt == r_last) begin
                            r_state    <= DONE;
                            r_ram_wr   <= 1'b0;
                            r_lsb_done <= 1'b1;
                        end else begin
                            r_cnt      <= r_cnt + 3'd1;
                            r_ram_a    <= w_ram_a_next;
                            r_ram_dout <= r_wdata[15:8];
                            r_wdata    <= {8'h00, r_wdata[31:8]};
                            r_ram_wr   <= ~w_stall_next;
                        end
                    end else begin
                        r_ram_wr <= ~w_stall_cur;
                    end
                end
                DONE: begin
                    r_state  <= IDLE;
                    r_ram_wr <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign if_done     = r_if_done;
    assign if_data     = r_if_data;
    assign lsb_done    = r_lsb_done;
    assign lsb_rdata   = r_lsb_rdata;
    assign ram_a       = r_ram_a;
    assign ram_dout    = r_ram_dout;
    assign ram_wr      = r_ram_wr;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_memory_controller.sv
// Directed bench for memory_controller: RAM model, write scoreboard and per-request latency/data checks.
module tb_memory_controller;
    import mem_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rdy_in;
    logic        clear_signal;
    logic        if_signal;
    logic [31:0] if_addr;
    logic        if_done;
    logic [31:0] if_data;
    logic        lsb_signal;
    logic        lsb_wr;
    logic        lsb_signed;
    logic [1:0]  lsb_len;
    logic [31:0] lsb_addr;
    logic [31:0] lsb_wdata;
    logic [31:0] lsb_rdata;
    logic        lsb_done;
    logic [7:0]  ram_din;
    logic [7:0]  ram_dout;
    logic [31:0] ram_a;
    logic        ram_wr;
    logic        io_buffer_full;
    mem_state_e  dbg_state;

    logic [7:0]  mem [0:8191];
    logic [39:0] exp_q[$];
    int          n_checks = 0;
    int          n_pass = 0;

    memory_controller dut (
        .clk_in         (clk),
        .rst_n_in       (rst_n),
        .rdy_in         (rdy_in),
        .clear_signal   (clear_signal),
        .if_signal      (if_signal),
        .if_addr        (if_addr),
        .if_done        (if_done),
        .if_data        (if_data),
        .lsb_signal     (lsb_signal),
        .lsb_wr         (lsb_wr),
        .lsb_signed     (lsb_signed),
        .lsb_len        (lsb_len),
        .lsb_addr       (lsb_addr),
        .lsb_wdata      (lsb_wdata),
        .lsb_rdata      (lsb_rdata),
        .lsb_done       (lsb_done),
        .ram_din        (ram_din),
        .ram_dout       (ram_dout),
        .ram_a          (ram_a),
        .ram_wr         (ram_wr),
        .io_buffer_full (io_buffer_full),
        .o_dbg_state    (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- RAM model and write scoreboard ----------------
    always @(posedge clk) ram_din <= mem[ram_a[12:0]];

    always @(negedge clk) begin
        if (rst_n && rdy_in && ram_wr) begin
            logic [39:0] exp_w;
            exp_w = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
            check("ram_write", {ram_a, ram_dout}, exp_w);
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    // ---------------- driver tasks ----------------
    // Called just after a rising edge; that cycle is cycle 0 of the request.
    task automatic do_req(input bit is_lsb, input bit wr, input bit sgn, input logic [1:0] len,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input int clr_cyc, input int rdy_from, input int rdy_n,
                          output int lat, output logic [31:0] data);
        logic d;
        lat  = -1;
        data = 32'd0;
        if (is_lsb) begin
            lsb_signal = 1'b1; lsb_wr = wr; lsb_signed = sgn; lsb_len = len;
            lsb_addr = addr; lsb_wdata = wdata;
        end else begin
            if_signal = 1'b1; if_addr = addr;
        end
        for (int k = 0; k < 30; k++) begin
            clear_signal = (k == clr_cyc);
            rdy_in = !(k >= rdy_from && k < rdy_from + rdy_n);
            @(negedge clk);
            d = is_lsb ? lsb_done : if_done;
            if (d) begin
                lat  = k;
                data = is_lsb ? lsb_rdata : if_data;
            end
            @(posedge clk); #1;
            if (lat >= 0) break;
        end
        if_signal = 1'b0; lsb_signal = 1'b0; clear_signal = 1'b0; rdy_in = 1'b1;
        @(negedge clk);
        check("done_one_cycle", is_lsb ? lsb_done : if_done, 1'b0);
        @(posedge clk); #1;
    endtask

    task automatic abort_req(input bit is_lsb, input logic [31:0] addr, input logic [1:0] len,
                             input int clr_cyc);
        logic seen;
        seen = 1'b0;
        if (is_lsb) begin
            lsb_wr = 1'b0; lsb_signed = 1'b0; lsb_len = len; lsb_addr = addr;
        end else begin
            if_addr = addr;
        end
        for (int k = 0; k < clr_cyc + 6; k++) begin
            clear_signal = (k == clr_cyc);
            if (is_lsb) lsb_signal = (k <= clr_cyc);
            else        if_signal  = (k <= clr_cyc);
            @(negedge clk);
            seen = seen | if_done | lsb_done;
            if (k == clr_cyc + 1) check("abort_idle", dbg_state, IDLE);
            @(posedge clk); #1;
        end
        clear_signal = 1'b0;
        check("abort_no_done", seen, 1'b0);
    endtask

    // ---------------- stimulus ----------------
    int          lat;
    logic [31:0] data;
    int          order[$];
    int          exp_order [4] = '{1, 0, 1, 0};

    initial begin
        rst_n = 1'b0; rdy_in = 1'b1; clear_signal = 1'b0; if_signal = 1'b0; if_addr = 32'd0;
        lsb_signal = 1'b0; lsb_wr = 1'b0; lsb_signed = 1'b0; lsb_len = 2'b00;
        lsb_addr = 32'd0; lsb_wdata = 32'd0; io_buffer_full = 1'b0;
        for (int i = 0; i < 8192; i++) mem[i] = 8'h00;
        mem[13'h1000] = 8'h13;
        mem[13'h0100] = 8'h80;
        mem[13'h0200] = 8'h34; mem[13'h0201] = 8'h92;
        mem[13'h0300] = 8'h78; mem[13'h0301] = 8'h56; mem[13'h0302] = 8'h34; mem[13'h0303] = 8'h12;
        mem[13'h1FFF] = 8'hAA; mem[13'h0000] = 8'h55;

        #12;
        check("rst_state", dbg_state, IDLE);
        check("rst_ram_wr", ram_wr, 1'b0);
        check("rst_ram_a", ram_a, 32'd0);
        check("rst_ram_dout", ram_dout, 8'd0);
        check("rst_if_done", if_done, 1'b0);
        check("rst_lsb_done", lsb_done, 1'b0);
        check("rst_if_data", if_data, 32'd0);
        check("rst_lsb_rdata", lsb_rdata, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Reads
        do_req(0, 0, 0, LEN_4B, 32'h1000, 32'd0, -1, 0, 0, lat, data);
        check("if4_lat", lat, 6);          check("if4_data", data, 32'h00000013);
        do_req(1, 0, 1, LEN_1B, 32'h0100, 32'd0, -1, 0, 0, lat, data);
        check("ld1s_lat", lat, 3);         check("ld1s_data", data, 32'hFFFFFF80);
        do_req(1, 0, 0, LEN_1B, 32'h0100, 32'd0, -1, 0, 0, lat, data);
        check("ld1u_lat", lat, 3);         check("ld1u_data", data, 32'h00000080);
        do_req(1, 0, 1, LEN_2B, 32'h0200, 32'd0, -1, 0, 0, lat, data);
        check("ld2s_lat", lat, 4);         check("ld2s_data", data, 32'hFFFF9234);
        do_req(1, 0, 1, LEN_4B, 32'h0300, 32'd0, -1, 0, 0, lat, data);
        check("ld4_lat", lat, 6);          check("ld4_data", data, 32'h12345678);
        do_req(1, 0, 1, 2'b10, 32'h0300, 32'd0, -1, 0, 0, lat, data);
        check("ld_len10_lat", lat, 6);     check("ld_len10_data", data, 32'h12345678);
        do_req(1, 0, 0, LEN_2B, 32'hFFFF_FFFF, 32'd0, -1, 0, 0, lat, data);
        check("ld_wrap_lat", lat, 4);      check("ld_wrap_data", data, 32'h000055AA);

        // Stores
        exp_q.push_back({32'h2000, 8'h34}); exp_q.push_back({32'h2001, 8'h12});
        do_req(1, 1, 0, LEN_2B, 32'h2000, 32'hABCD1234, -1, 0, 0, lat, data);
        check("st2_lat", lat, 3);
        exp_q.push_back({32'h2100, 8'hEF}); exp_q.push_back({32'h2101, 8'hBE});
        exp_q.push_back({32'h2102, 8'hAD}); exp_q.push_back({32'h2103, 8'hDE});
        do_req(1, 1, 0, LEN_4B, 32'h2100, 32'hDEADBEEF, 2, 0, 0, lat, data);
        check("st4_clear_lat", lat, 5);
        exp_q.push_back({32'h2180, 8'h77});
        do_req(1, 1, 0, LEN_1B, 32'h2180, 32'h00000077, 0, 0, 0, lat, data);
        check("st1_clear_idle_lat", lat, 2);
        exp_q.push_back({32'h2300, 8'hA5}); exp_q.push_back({32'h2301, 8'hC3});
        do_req(1, 1, 0, LEN_2B, 32'h2300, 32'h0000C3A5, -1, 1, 2, lat, data);
        check("st2_rdy_lat", lat, 5);

        // Flush behaviour
        abort_req(0, 32'h1000, LEN_4B, 3);
        abort_req(1, 32'h0100, LEN_1B, 2);
        if_signal = 1'b1; if_addr = 32'h1000; lsb_signal = 1'b1; lsb_wr = 1'b0;
        lsb_len = LEN_1B; lsb_addr = 32'h0100; clear_signal = 1'b1;
        @(posedge clk); #1;
        if_signal = 1'b0; lsb_signal = 1'b0; clear_signal = 1'b0;
        @(negedge clk);
        check("clear_idle_no_grant", dbg_state, IDLE);
        @(posedge clk); #1;

        // Round-robin with both requesters held high, starting from last_grant=IF
        rst_n = 1'b0; #2; rst_n = 1'b1;
        @(posedge clk); #1;
        if_signal = 1'b1; if_addr = 32'h1000;
        lsb_signal = 1'b1; lsb_wr = 1'b0; lsb_signed = 1'b0; lsb_len = LEN_1B; lsb_addr = 32'h0100;
        for (int k = 0; k < 24; k++) begin
            @(negedge clk);
            if (lsb_done) begin
                if (order.size() == 0) check("arb_first_rdata", lsb_rdata, 32'h00000080);
                order.push_back(1);
            end
            if (if_done) order.push_back(0);
            @(posedge clk); #1;
        end
        for (int i = 0; i < 4; i++)
            check("arb_order", (order.size() > i) ? order[i] : 9, exp_order[i]);
        if_signal = 1'b0; lsb_signal = 1'b0;
        rst_n = 1'b0; #2; rst_n = 1'b1;
        @(posedge clk); #1;

        // Asynchronous reset in the middle of a store
        exp_q.push_back({32'h2200, 8'h44});
        lsb_signal = 1'b1; lsb_wr = 1'b1; lsb_len = LEN_4B; lsb_addr = 32'h2200; lsb_wdata = 32'h11223344;
        @(posedge clk); #1;
        @(posedge clk); #2;
        check("mid_write_wr_before", ram_wr, 1'b1);
        rst_n = 1'b0; lsb_signal = 1'b0;
        #1;
        check("async_rst_ram_wr", ram_wr, 1'b0);
        check("async_rst_state", dbg_state, IDLE);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

`ifdef MEM_CTRL_IO_STALL_EN
        exp_q.push_back({32'h0003_0000, 8'h5C});
        lat = -1;
        lsb_signal = 1'b1; lsb_wr = 1'b1; lsb_len = LEN_1B; lsb_addr = 32'h0003_0000; lsb_wdata = 32'h5C;
        for (int k = 0; k < 12; k++) begin
            io_buffer_full = (k < 3);
            @(negedge clk);
            if (k >= 1 && k <= 3) check("io_stall_wr_low", ram_wr, 1'b0);
            if (lsb_done && lat < 0) lat = k;
            @(posedge clk); #1;
            if (lat >= 0) break;
        end
        lsb_signal = 1'b0; io_buffer_full = 1'b0;
        check("io_stall_lat", lat, 5);
`endif

        repeat (3) @(posedge clk);
        check("all_writes_seen", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
